// File: rtl/apb_multi_timer_pkg.sv
// Shared register map, CTRL bit positions and the CTRL struct for the multi-channel timer.
// Pure definitions: no logic, no latency, no flow control.
package apb_multi_timer_pkg;

  localparam logic [3:0]  OFF_LOAD      = 4'h0;
  localparam logic [3:0]  OFF_CTRL      = 4'h4;
  localparam logic [3:0]  OFF_COUNT     = 4'h8;
  localparam logic [3:0]  OFF_STATUS    = 4'hC;
  localparam logic [15:0] ADDR_PRESCALE = 16'h0100;
  localparam logic [15:0] ADDR_IRQ_SUM  = 16'h0104;
  localparam int          CH_STRIDE     = 'h10;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_IE      = 2;

  typedef struct packed {
    logic ie;
    logic oneshot;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/apb_multi_timer_if.sv
// APB slave bundle for the timer register block; zero wait state, so pready is constant 1.
// No internal latency; the slave never stalls the master.
interface apb_multi_timer_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_multi_timer_channel.sv
// One countdown channel: LOAD/CTRL registers, counter, sticky expire flag and registered irq.
// Writes and expiries act on the clock edge, irq lags the expire flag by one cycle; no backpressure.
module timer_channel
  import apb_multi_timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             load_we,
  input  logic [WIDTH-1:0] load_wdat,
  input  logic             ctrl_we,
  input  ctrl_t            ctrl_wdat,
  input  logic             status_clr,
  output logic [WIDTH-1:0] load,
  output ctrl_t            ctrl,
  output logic [WIDTH-1:0] count,
  output logic             exp,
  output logic             irq
);
  logic expire;
  logic start;

  // COUNT of 0 or 1 both expire, so LOAD=0 gives a one-tick period
  assign expire = tick & ctrl.en & (count <= WIDTH'(1));
  assign start  = ctrl_we & ctrl_wdat.en & ~ctrl.en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load  <= '0;
      ctrl  <= '0;
      count <= '0;
      exp   <= 1'b0;
      irq   <= 1'b0;
    end else begin
      if (load_we) load <= load_wdat;

      if (ctrl_we)                     ctrl    <= ctrl_wdat;
      else if (expire && ctrl.oneshot) ctrl.en <= 1'b0;

      if (start)                count <= load;
      else if (expire)          count <= ctrl.oneshot ? '0 : load;
      else if (tick && ctrl.en) count <= count - WIDTH'(1);

      // a fresh expiry beats a concurrent write-1-to-clear
      if (expire)          exp <= 1'b1;
      else if (status_clr) exp <= 1'b0;

      irq <= exp & ctrl.ie;
    end
  end
endmodule

// File: rtl/apb_multi_timer.sv
// NUM_CH countdown timers behind an APB slave: address decode, shared prescaler, interrupt combining.
// Reads are combinational, writes commit in the access phase, irq is registered; pready is always 1.
module apb_multi_timer
  import apb_multi_timer_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int WIDTH   = 16,
  parameter int PRESC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  apb_multi_timer_if.slave  apb,
  output logic [NUM_CH-1:0] irq_ch,
  output logic              irq
);
  localparam logic [15:0] CH_SPACE = 16'(NUM_CH * CH_STRIDE);

  logic               acc_wr;
  logic               in_ch;
  logic               is_presc;
  logic               is_sum;
  logic [3:0]         ch_idx;
  logic [1:0]         reg_sel;
  logic               tick;
  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_cnt;
  logic [NUM_CH-1:0]  exp_v;
  logic [NUM_CH-1:0]  ie_v;
  logic [WIDTH-1:0]   load_v  [NUM_CH];
  logic [WIDTH-1:0]   count_v [NUM_CH];
  ctrl_t              ctrl_v  [NUM_CH];
  logic               unused_pwdata;

  assign acc_wr        = apb.psel & apb.penable & apb.pwrite;
  assign in_ch         = apb.paddr < CH_SPACE;
  assign is_presc      = apb.paddr == ADDR_PRESCALE;
  assign is_sum        = apb.paddr == ADDR_IRQ_SUM;
  assign ch_idx        = apb.paddr[7:4];
  assign reg_sel       = apb.paddr[3:2];
  assign apb.pready    = 1'b1;
  assign apb.pslverr   = apb.psel & apb.penable & ~(in_ch | is_presc | is_sum);
  assign unused_pwdata = ^apb.pwdata;

  // New PRESCALE values only land when the down-counter next reloads
  assign tick = (presc_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      presc_cnt <= '0;
      irq       <= 1'b0;
    end else begin
      if (acc_wr && is_presc) presc_q <= apb.pwdata[PRESC_W-1:0];
      presc_cnt <= tick ? presc_q : presc_cnt - PRESC_W'(1);
      irq       <= |(exp_v & ie_v);
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic sel;
    assign sel     = acc_wr & in_ch & (ch_idx == 4'(n));
    assign ie_v[n] = ctrl_v[n].ie;

    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .load_we    (sel && (reg_sel == OFF_LOAD[3:2])),
      .load_wdat  (apb.pwdata[WIDTH-1:0]),
      .ctrl_we    (sel && (reg_sel == OFF_CTRL[3:2])),
      .ctrl_wdat  (ctrl_t'(apb.pwdata[CTRL_IE:CTRL_EN])),
      .status_clr (sel && (reg_sel == OFF_STATUS[3:2]) && apb.pwdata[0]),
      .load       (load_v[n]),
      .ctrl       (ctrl_v[n]),
      .count      (count_v[n]),
      .exp        (exp_v[n]),
      .irq        (irq_ch[n])
    );
  end

  always_comb begin
    apb.prdata = '0;
    if (is_presc) begin
      apb.prdata[PRESC_W-1:0] = presc_q;
    end else if (is_sum) begin
      apb.prdata[NUM_CH-1:0] = exp_v;
    end else if (in_ch) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_idx == 4'(c)) begin
          case (reg_sel)
            OFF_LOAD[3:2]:  apb.prdata[WIDTH-1:0] = load_v[c];
            OFF_CTRL[3:2]:  apb.prdata[2:0]       = ctrl_v[c];
            OFF_COUNT[3:2]: apb.prdata[WIDTH-1:0] = count_v[c];
            default:        apb.prdata[0]         = exp_v[c];
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_apb_multi_timer.sv
// Bench for apb_multi_timer: directed scenarios with hand-derived constants plus a randomized run
// checked against a register-level reference model.
module tb_apb_multi_timer;
  localparam int          NUM_CH  = 4;
  localparam int          WIDTH   = 16;
  localparam int          PRESC_W = 8;
  localparam logic [31:0] LMASK   = 32'h0000_FFFF;
  localparam logic [31:0] PMASK   = 32'h0000_00FF;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] irq_ch;
  logic              irq;
  int                n_tests = 0;
  int                n_fail  = 0;

  apb_multi_timer_if bus ();

  apb_multi_timer #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .apb    (bus),
    .irq_ch (irq_ch),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  // Reference model: architectural register state, advanced once per clock edge
  logic [31:0]       m_load [NUM_CH];
  logic [31:0]       m_cnt  [NUM_CH];
  bit                m_en   [NUM_CH];
  bit                m_os   [NUM_CH];
  bit                m_ie   [NUM_CH];
  bit                m_exp  [NUM_CH];
  logic [31:0]       m_presc;
  logic [31:0]       m_pcnt;
  logic [NUM_CH-1:0] m_irqch;
  bit                m_irq;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_load[c] <= 0; m_cnt[c] <= 0; m_en[c] <= 0;
        m_os[c] <= 0; m_ie[c] <= 0; m_exp[c] <= 0;
      end
      m_presc <= 0; m_pcnt <= 0; m_irqch <= '0; m_irq <= 0;
    end else begin : step
      bit tk, wr, fire, mine, any;
      int csel, off;
      tk   = (m_pcnt == 0);
      wr   = bus.psel && bus.penable && bus.pwrite;
      csel = int'(bus.paddr[7:4]);
      off  = int'(bus.paddr[3:0]);
      any  = 0;
      m_pcnt <= tk ? m_presc : m_pcnt - 1;
      if (wr && bus.paddr == 16'h0100) m_presc <= bus.pwdata & PMASK;
      for (int c = 0; c < NUM_CH; c++) begin
        mine = wr && (bus.paddr < 16'(NUM_CH * 16)) && (csel == c);
        fire = tk && m_en[c] && (m_cnt[c] <= 1);
        m_irqch[c] <= m_exp[c] && m_ie[c];
        if (m_exp[c] && m_ie[c]) any = 1;
        if (mine && off == 0) m_load[c] <= bus.pwdata & LMASK;
        if (mine && off == 4) begin
          m_en[c] <= bus.pwdata[0]; m_os[c] <= bus.pwdata[1]; m_ie[c] <= bus.pwdata[2];
        end else if (fire && m_os[c]) begin
          m_en[c] <= 0;
        end
        if (mine && off == 4 && bus.pwdata[0] && !m_en[c]) m_cnt[c] <= m_load[c];
        else if (fire)                                     m_cnt[c] <= m_os[c] ? 0 : m_load[c];
        else if (tk && m_en[c])                            m_cnt[c] <= m_cnt[c] - 1;
        if (fire)                                      m_exp[c] <= 1;
        else if (mine && off == 12 && bus.pwdata[0])   m_exp[c] <= 0;
      end
      m_irq <= any;
    end
  end

  function automatic logic [31:0] m_read(input logic [15:0] a);
    logic [31:0] r;
    int c;
    r = 0;
    c = int'(a[7:4]);
    if (a < 16'(NUM_CH * 16)) begin
      case (int'(a[3:0]))
        0:  r = m_load[c];
        4:  r = {29'b0, m_ie[c], m_os[c], m_en[c]};
        8:  r = m_cnt[c];
        12: r = {31'b0, m_exp[c]};
        default: r = 0;
      endcase
    end else if (a == 16'h0100) begin
      r = m_presc;
    end else if (a == 16'h0104) begin
      for (int k = 0; k < NUM_CH; k++) r[k] = m_exp[k];
    end
    return r;
  endfunction

  function automatic bit m_mapped(input logic [15:0] a);
    return (a < 16'(NUM_CH * 16)) || (a == 16'h0100) || (a == 16'h0104);
  endfunction

  task automatic apb_xfer(input bit w, input logic [15:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic err);
    @(negedge clk);
    bus.psel = 1; bus.penable = 0; bus.pwrite = w; bus.paddr = a; bus.pwdata = d;
    @(negedge clk);
    bus.penable = 1;
    #1;
    rd  = bus.prdata;
    err = bus.pslverr;
    @(negedge clk);
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic        err;
    apb_xfer(1'b1, a, d, rd, err);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = 0; bus.pwdata = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    logic [15:0] addrs [8];
    addrs = '{16'h000, 16'h004, 16'h008, 16'h00C, 16'h034, 16'h038, 16'h100, 16'h104};
    rst_n = 0;
    repeat (2) @(negedge clk);
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
    n_tests++; if (irq_ch !== 4'h0) begin n_fail++; $display("FAIL reset_irq_ch got %b want 0", irq_ch); end
    n_tests++; if (bus.pslverr !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr got %b want 0", bus.pslverr); end
    n_tests++; if (bus.pready !== 1'b1) begin n_fail++; $display("FAIL reset_pready got %b want 1", bus.pready); end
    foreach (addrs[i]) begin
      bus.paddr = addrs[i];
      #1;
      n_tests++;
      if (bus.prdata !== 32'h0) begin
        n_fail++; $display("FAIL reset_prdata addr %h got %h want 0", addrs[i], bus.prdata);
      end
    end
    rst_n = 1;
  endtask

  task automatic test_periodic();
    do_reset();
    wr(16'h000, 5);
    wr(16'h004, 5);
    bus.paddr = 16'h008;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_tests++;
      if (bus.prdata !== 32'(5 - k)) begin
        n_fail++; $display("FAIL periodic_count step %0d got %0d want %0d", k, bus.prdata, 5 - k);
      end
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL periodic_irq_early step %0d got %b want 0", k, irq); end
      @(negedge clk);
    end
    #1;
    n_tests++; if (bus.prdata !== 32'd5) begin n_fail++; $display("FAIL periodic_reload got %0d want 5", bus.prdata); end
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL periodic_irq_lag got %b want 0", irq); end
    bus.paddr = 16'h00C;
    #1;
    n_tests++; if (bus.prdata !== 32'd1) begin n_fail++; $display("FAIL periodic_exp got %0d want 1", bus.prdata); end
    @(negedge clk);
    bus.paddr = 16'h008;
    #1;
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL periodic_irq got %b want 1", irq); end
    n_tests++; if (irq_ch !== 4'b0001) begin n_fail++; $display("FAIL periodic_irq_ch got %b want 0001", irq_ch); end
    n_tests++; if (bus.prdata !== 32'd4) begin n_fail++; $display("FAIL periodic_count_after got %0d want 4", bus.prdata); end
    repeat (4) @(negedge clk);
    #1;
    n_tests++; if (bus.prdata !== 32'd5) begin n_fail++; $display("FAIL periodic_second_reload got %0d want 5", bus.prdata); end
  endtask

  task automatic test_oneshot();
    int found;
    do_reset();
    wr(16'h100, 3);
    wr(16'h010, 3);
    wr(16'h014, 3);
    bus.paddr = 16'h104;
    found = -1;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      #1;
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_irq cycle %0d got %b want 0", j, irq); end
      if (found < 0 && bus.prdata == 32'h2) found = j;
    end
    n_tests++;
    if (found < 9 || found > 12) begin
      n_fail++; $display("FAIL oneshot_latency got %0d want 9..12", found);
    end
    #1;
    n_tests++; if (bus.prdata !== 32'h2) begin n_fail++; $display("FAIL oneshot_irq_sum got %h want 2", bus.prdata); end
    bus.paddr = 16'h014;
    #1;
    n_tests++; if (bus.prdata !== 32'h2) begin n_fail++; $display("FAIL oneshot_ctrl got %h want 2", bus.prdata); end
    bus.paddr = 16'h018;
    #1;
    n_tests++; if (bus.prdata !== 32'h0) begin n_fail++; $display("FAIL oneshot_count got %h want 0", bus.prdata); end
    n_tests++; if (irq_ch !== 4'h0) begin n_fail++; $display("FAIL oneshot_irq_ch got %b want 0", irq_ch); end
  endtask

  task automatic test_w1c();
    do_reset();
    wr(16'h000, 5);
    wr(16'h004, 5);
    repeat (6) @(negedge clk);
    #1;
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL w1c_irq_before got %b want 1", irq); end
    wr(16'h00C, 1);
    bus.paddr = 16'h00C;
    #1;
    n_tests++; if (bus.prdata !== 32'd0) begin n_fail++; $display("FAIL w1c_clear got %0d want 0", bus.prdata); end
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL w1c_irq_hold got %b want 1", irq); end
    @(negedge clk);
    #1;
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_irq_drop got %b want 0", irq); end
    n_tests++; if (bus.prdata !== 32'd1) begin n_fail++; $display("FAIL w1c_reexpire got %0d want 1", bus.prdata); end
    @(negedge clk);
    @(negedge clk);
    wr(16'h00C, 1);
    #1;
    n_tests++; if (bus.prdata !== 32'd1) begin n_fail++; $display("FAIL w1c_set_wins got %0d want 1", bus.prdata); end
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL w1c_set_irq got %b want 1", irq); end
    @(negedge clk);
    #1;
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL w1c_set_irq_after got %b want 1", irq); end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd;
    logic        err;
    do_reset();
    wr(16'h000, 7);
    apb_xfer(1'b0, 16'h0F0, 0, rd, err);
    n_tests++; if (err !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL unmapped_rd_f0 got err %b data %h want 1 0", err, rd); end
    apb_xfer(1'b0, 16'h108, 0, rd, err);
    n_tests++; if (err !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL unmapped_rd_108 got err %b data %h want 1 0", err, rd); end
    apb_xfer(1'b1, 16'h0F0, 32'hFFFF_FFFF, rd, err);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL unmapped_wr_f0 got err %b want 1", err); end
    apb_xfer(1'b1, 16'h040, 32'hFFFF_FFFF, rd, err);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL unmapped_wr_40 got err %b want 1", err); end
    apb_xfer(1'b1, 16'h108, 32'hFFFF_FFFF, rd, err);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL unmapped_wr_108 got err %b want 1", err); end
    apb_xfer(1'b0, 16'h000, 0, rd, err);
    n_tests++; if (err !== 1'b0 || rd !== 32'h7) begin n_fail++; $display("FAIL unmapped_no_change got err %b data %h want 0 7", err, rd); end
    apb_xfer(1'b0, 16'h100, 0, rd, err);
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL unmapped_presc got %h want 0", rd); end
    wr(16'h000, 32'h0001_2345);
    apb_xfer(1'b0, 16'h000, 0, rd, err);
    n_tests++; if (rd !== 32'h2345) begin n_fail++; $display("FAIL load_trunc got %h want 2345", rd); end
    wr(16'h100, 32'hFFFF_FF07);
    apb_xfer(1'b0, 16'h100, 0, rd, err);
    n_tests++; if (rd !== 32'h07) begin n_fail++; $display("FAIL presc_trunc got %h want 07", rd); end
    wr(16'h034, 32'hFFFF_FFF4);
    apb_xfer(1'b0, 16'h034, 0, rd, err);
    n_tests++; if (rd !== 32'h4) begin n_fail++; $display("FAIL ctrl_trunc got %h want 4", rd); end
  endtask

  task automatic test_reset_mid();
    int waited;
    do_reset();
    wr(16'h020, 3);
    wr(16'h024, 5);
    waited = 0;
    while (irq !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL resetmid_irq_timeout got %b want 1", irq); end
    #2;
    rst_n = 0;
    bus.paddr = 16'h028;
    #1;
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL resetmid_irq got %b want 0", irq); end
    n_tests++; if (irq_ch !== 4'h0) begin n_fail++; $display("FAIL resetmid_irq_ch got %b want 0", irq_ch); end
    n_tests++; if (bus.prdata !== 32'h0) begin n_fail++; $display("FAIL resetmid_count got %h want 0", bus.prdata); end
    bus.paddr = 16'h024;
    #1;
    n_tests++; if (bus.prdata !== 32'h0) begin n_fail++; $display("FAIL resetmid_ctrl got %h want 0", bus.prdata); end
    @(negedge clk);
    rst_n = 1;
    repeat (10) @(negedge clk);
    bus.paddr = 16'h028;
    #1;
    n_tests++; if (bus.prdata !== 32'h0) begin n_fail++; $display("FAIL resetmid_idle_count got %h want 0", bus.prdata); end
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL resetmid_idle_irq got %b want 0", irq); end
  endtask

  task automatic test_load_change();
    logic [31:0] want_cnt [7];
    logic [31:0] want_exp [7];
    want_cnt = '{2, 1, 2, 1, 2, 1, 2};
    want_exp = '{0, 0, 1, 1, 1, 1, 1};
    do_reset();
    wr(16'h000, 5);
    wr(16'h004, 1);
    wr(16'h000, 2);
    for (int k = 0; k < 7; k++) begin
      bus.paddr = 16'h008;
      #1;
      n_tests++;
      if (bus.prdata !== want_cnt[k]) begin
        n_fail++; $display("FAIL loadchg_count step %0d got %0d want %0d", k, bus.prdata, want_cnt[k]);
      end
      bus.paddr = 16'h104;
      #1;
      n_tests++;
      if (bus.prdata !== want_exp[k]) begin
        n_fail++; $display("FAIL loadchg_exp step %0d got %h want %h", k, bus.prdata, want_exp[k]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int          phase;
    int          kind;
    int          c;
    logic [15:0] a;
    logic [31:0] d;
    do_reset();
    phase = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      n_tests++;
      if (irq !== m_irq) begin n_fail++; $display("FAIL rand_irq cycle %0d got %b want %b", i, irq, m_irq); end
      n_tests++;
      if (irq_ch !== m_irqch) begin n_fail++; $display("FAIL rand_irq_ch cycle %0d got %b want %b", i, irq_ch, m_irqch); end
      n_tests++;
      if (bus.prdata !== m_read(bus.paddr)) begin
        n_fail++; $display("FAIL rand_prdata cycle %0d addr %h got %h want %h", i, bus.paddr, bus.prdata, m_read(bus.paddr));
      end
      n_tests++;
      if (bus.pslverr !== (bus.psel && bus.penable && !m_mapped(bus.paddr))) begin
        n_fail++; $display("FAIL rand_pslverr cycle %0d addr %h got %b", i, bus.paddr, bus.pslverr);
      end
      if (phase == 1) begin
        bus.penable = 1;
        phase = 2;
      end else if (phase == 2) begin
        bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
        phase = 0;
      end else if ($urandom_range(0, 2) != 0) begin
        kind = $urandom_range(0, 9);
        c    = $urandom_range(0, NUM_CH - 1);
        d    = $urandom;
        case (kind)
          7: begin a = 16'h100; d = (d & 32'hFFFF_FF00) | $urandom_range(0, 2); end
          8: a = 16'h104;
          9: a = ($urandom_range(0, 1) == 1) ? 16'h0F0 : 16'h108;
          default: begin
            a = 16'(c * 16 + $urandom_range(0, 3) * 4);
            if (a[3:0] == 4'h0) d = (d & 32'hFFF8_0000) | $urandom_range(0, 6);
          end
        endcase
        bus.psel = 1; bus.penable = 0; bus.pwrite = ($urandom_range(0, 2) != 0);
        bus.paddr = a; bus.pwdata = d;
        phase = 1;
      end
    end
    @(negedge clk);
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout tests %0d failed %0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = 0; bus.pwdata = 0;
    test_reset();
    test_periodic();
    test_oneshot();
    test_w1c();
    test_unmapped();
    test_reset_mid();
    test_load_change();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_multi_timer.md
Name: apb_multi_timer

Overview:
Parametrised multi-channel countdown timer with an APB slave register interface. It provides NUM_CH independent timers and a shared prescaler. Each channel has runtime-selectable periodic or one-shot mode, an interrupt enable, and a sticky W1C status bit. It sits on the peripheral APB bus and drives per-channel and combined interrupt lines to the interrupt controller.

Parameters:
NUM_CH, 4, number of timer channels (1..16)
WIDTH, 16, counter and LOAD width (1..32)
PRESC_W, 8, prescaler width (1..32)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
psel  input  1  APB select
penable  input  1  APB enable (access phase)
pwrite  input  1  APB write
paddr  input  16  APB byte address
pwdata  input  32  APB write data
prdata  output  32  APB read data (combinational from paddr)
pready  output  1  tied 1, zero wait states
pslverr  output  1  error on an unmapped address during the access phase
irq_ch  output  NUM_CH  per-channel registered interrupt
irq  output  1  registered OR of all channel interrupts

Behaviour:
- Reset: all registers, counters and prescaler are 0. irq, irq_ch, pslverr and prdata are 0.
- Access: writes commit when psel & penable & pwrite. Reads of unmapped addresses return 0. pslverr = psel & penable & unmapped.
- Channel n register block, base n*0x10:
  - +0x0 LOAD: RW, bits [WIDTH-1:0].
  - +0x4 CTRL: RW. bit0 EN, bit1 ONESHOT, bit2 IE.
  - +0x8 COUNT: RO.
  - +0xC STATUS: bit0 EXP, write 1 to clear.
- Global registers:
  - 0x100 PRESCALE: RW, [PRESC_W-1:0].
  - 0x104 IRQ_SUM: RO, bit n = EXP[n].
  - Any address >= NUM_CH*0x10 other than these two is unmapped.
- Prescaler: free-running down-counter. tick=1 for one cycle when it is 0, then it reloads PRESCALE. A tick therefore occurs every PRESCALE+1 cycles. Writing PRESCALE takes effect at the next reload.
- Enable: a CTRL write that changes EN 0->1 loads COUNT<=LOAD in the same edge. EN=0 freezes COUNT. Writing LOAD never disturbs a running COUNT; the new value applies at the next reload.
- On tick with EN=1:
  - If COUNT<=1: expire event. Set EXP. If periodic, COUNT<=LOAD. If one-shot, COUNT<=0 and EN<=0 (hardware clear, visible in CTRL).
  - Otherwise COUNT<=COUNT-1.
  - Resulting period is LOAD ticks. LOAD=0 behaves as 1.
- Simultaneous events:
  - Expire and W1C of EXP in the same cycle: set wins.
  - Expire and a software CTRL write to EN in the same cycle: the software value wins.
- Interrupts:
  - irq_ch[n] <= EXP[n] & IE[n], registered.
  - irq <= |(EXP & IE), registered.
  - Latency: EXP is visible one edge after the expiring tick edge; irq follows one edge later.
  - Clearing IE masks the interrupt but leaves EXP set.
- Reset mid-operation: all state returns to reset values immediately (asynchronously). Counting resumes only after software re-enables the channel.
- WIDTH<32: upper read bits are 0 and upper write bits are ignored.

Decomposition:
- Package apb_multi_timer_pkg:
  - Register offset constants (LOAD/CTRL/COUNT/STATUS, PRESCALE, IRQ_SUM, CH_STRIDE=0x10).
  - CTRL bit indices.
  - A ctrl_t packed struct {ie, oneshot, en}.
- Sub-module timer_channel (parameter WIDTH):
  - Inputs: tick, load value, ctrl, write strobes.
  - Outputs: count, exp, irq.
  - Instantiated NUM_CH times via generate.
- The top level holds APB decode, the prescaler and interrupt combining.

Test Plan:
1. NUM_CH=4, WIDTH=16, PRESCALE=0. ch0 LOAD=5, CTRL=0x5 (EN, IE, periodic) -> COUNT reads 5,4,3,2,1 on successive cycles; EXP sets 5 cycles after enable; irq_ch[0] and irq rise 1 cycle later; COUNT reloads 5 and repeats every 5 cycles.
2. ch1 LOAD=3, CTRL=0x3 (one-shot, IE=0), PRESCALE=3 -> single expire after 12 cycles; CTRL reads 0x2 (EN cleared); COUNT holds 0; irq stays 0; IRQ_SUM=0x2.
3. Write STATUS ch0=1 on the exact cycle of a new expire -> EXP remains 1 and irq stays high. A clear on a non-expire cycle -> irq drops 1 cycle later.
4. Read/write 0x0F0 and 0x108 -> pslverr=1 in the access phase and prdata=0; no register changes. Write LOAD=0x12345 with WIDTH=16 -> reads back 0x2345.
5. Assert rst_n low mid-count with ch2 running and irq high -> irq, irq_ch, COUNT and CTRL are 0 immediately. After release, no counting until CTRL is written.
6. Change LOAD from 5 to 2 while ch0 is running at COUNT=3 -> current period completes at 5 ticks total; subsequent periods are 2 ticks.
